// File: rtl/counter_reload_ctrl.sv
// Write-side controller for a loadable counter: loads a start value, watches for
// the end value, pulses hit per match (optionally reloading) and flags a stuck counter.
module counter_reload_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] data_cnt,
  output logic [WIDTH-1:0] wdata,
  output logic             wr,
  output logic             busy,
  output logic             hit,
  output logic [7:0]       hit_count,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] ereg_q, ereg_d;
  logic             areg_q, areg_d;
  logic [WIDTH-1:0] wdog_q, wdog_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic             busy_q, busy_d;
  logic             hit_q, hit_d;
  logic [7:0]       hit_count_q, hit_count_d;
  logic             err_q, err_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    ereg_d      = ereg_q;
    areg_d      = areg_q;
    wdog_d      = wdog_q;
    hit_d       = 1'b0;
    hit_count_d = hit_count_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          sreg_d      = start_val;
          ereg_d      = end_val;
          areg_d      = auto_reload;
          hit_count_d = 8'd0;
          err_d       = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
          wdog_d  = '0;
        end
      end
      RUN: begin
        // Stop wins over a match at the same edge.
        if (stop) begin
          state_d = IDLE;
        end else if (data_cnt == ereg_q) begin
          hit_d       = 1'b1;
          hit_count_d = sat_inc(hit_count_q);
          state_d     = areg_q ? LOAD : IDLE;
        end else if (wdog_q == {WIDTH{1'b1}}) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Load strobe and busy follow the next state so they line up with LOAD/RUN.
    wr_d    = (state_d == LOAD);
    wdata_d = (state_d == LOAD) ? sreg_d : wdata_q;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      ereg_q      <= '0;
      areg_q      <= 1'b0;
      wdog_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_count_q <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      ereg_q      <= ereg_d;
      areg_q      <= areg_d;
      wdog_q      <= wdog_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
      err_q       <= err_d;
    end
  end

  assign wdata     = wdata_q;
  assign wr        = wr_q;
  assign busy      = busy_q;
  assign hit       = hit_q;
  assign hit_count = hit_count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_counter_reload_ctrl.sv
// Bench for counter_reload_ctrl with an attached behavioural counter; expected hit
// events (cycle and count) are queued at start and matched as hit pulses appear.
module tb_counter_reload_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [7:0] start_val;
  logic [7:0] end_val;
  logic       auto_reload;
  logic [7:0] data_cnt;
  logic [7:0] wdata;
  logic       wr;
  logic       busy;
  logic       hit;
  logic [7:0] hit_count;
  logic       err;

  logic [7:0] cnt = 8'd0;
  logic       stuck = 1'b0;
  int         cyc = 0;
  int         e0 = 0;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    int cyc;
    int cnt;
  } hit_t;
  hit_t exp_q[$];

  counter_reload_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .start_val  (start_val),
    .end_val    (end_val),
    .auto_reload(auto_reload),
    .data_cnt   (data_cnt),
    .wdata      (wdata),
    .wr         (wr),
    .busy       (busy),
    .hit        (hit),
    .hit_count  (hit_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    cnt <= wr ? wdata : cnt + 8'd1;
  end

  assign data_cnt = stuck ? 8'h00 : cnt;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset && hit) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_hit", 32'(hit), 0);
      end else begin
        hit_t e;
        e = exp_q.pop_front();
        chk("hit_cycle", cyc, e.cyc);
        chk("hit_count_at_hit", hit_count, e.cnt);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the next edge (E0).
  task automatic start_run(input logic [7:0] sv, input logic [7:0] ev,
                           input logic ar, input int nexp);
    int d;
    start_val   = sv;
    end_val     = ev;
    auto_reload = ar;
    start       = 1'b1;
    reset       = 1'b1;
    e0          = cyc + 1;
    d           = int'(8'(ev - sv));
    for (int k = 0; k < nexp; k++)
      exp_q.push_back('{cyc: e0 + 2 + d + k * (d + 2), cnt: (k + 1 > 255) ? 255 : k + 1});
    @(negedge clk);
    start = 1'b0;
    chk("load_wr", wr, 1);
    chk("load_wdata", wdata, sv);
    chk("load_busy", busy, 1);
    chk("start_clears_count", hit_count, 0);
    chk("start_clears_err", err, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; stop = 1'b0;
    start_val = 8'h10; end_val = 8'h14; auto_reload = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr", wr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_err", err, 0);

    // One-shot 0x10 -> 0x14, start accepted at the first edge after release.
    start_run(8'h10, 8'h14, 1'b0, 1);
    wait_until(e0 + 2);
    chk("wr_one_cycle", wr, 0);
    chk("busy_in_run", busy, 1);
    wait_until(e0 + 6);
    chk("oneshot_busy_falls", busy, 0);
    wait_until(e0 + 7);
    chk("oneshot_pending", exp_q.size(), 0);
    chk("oneshot_count", hit_count, 1);

    start_run(8'hFE, 8'h01, 1'b0, 1);
    wait_until(e0 + 6);
    chk("wrap_pending", exp_q.size(), 0);

    start_run(8'h55, 8'h55, 1'b0, 1);
    wait_until(e0 + 3);
    chk("equal_pending", exp_q.size(), 0);

    // Auto-reload, period 5, long enough to saturate; collide a start mid-run.
    start_run(8'h00, 8'h03, 1'b1, 260);
    wait_until(e0 + 5 + 5 * 10 + 1);
    start_val = 8'h40; end_val = 8'h90; auto_reload = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(e0 + 5 + 5 * 259);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("auto_stop_busy", busy, 0);
    chk("auto_stop_wr", wr, 0);
    chk("auto_sat_count", hit_count, 255);
    repeat (8) @(negedge clk);
    chk("auto_pending", exp_q.size(), 0);
    chk("auto_count_kept", hit_count, 255);

    // Stop on the match edge suppresses the hit.
    start_run(8'h20, 8'h23, 1'b0, 0);
    wait_until(e0 + 4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stopmatch_busy", busy, 0);
    chk("stopmatch_hit", hit, 0);
    chk("stopmatch_wr", wr, 0);
    chk("stopmatch_count", hit_count, 0);
    repeat (6) @(negedge clk);

    // Stop beats start in IDLE.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("idle_stop_busy", busy, 0);
    chk("idle_stop_wr", wr, 0);

    // Reset in the middle of a run.
    start_run(8'h00, 8'h50, 1'b1, 0);
    wait_until(e0 + 3);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_wr", wr, 0);
    repeat (2) @(negedge clk);

    // Watchdog with the counter output stuck at zero.
    stuck = 1'b1;
    start_run(8'h00, 8'h80, 1'b0, 0);
    wait_until(e0 + 256);
    chk("wdog_err_early", err, 0);
    chk("wdog_busy_early", busy, 1);
    @(negedge clk);
    chk("wdog_err", err, 1);
    chk("wdog_busy", busy, 0);
    stuck = 1'b0;
    start_run(8'h33, 8'h33, 1'b0, 1);
    wait_until(e0 + 3);
    chk("after_wdog_pending", exp_q.size(), 0);
    chk("after_wdog_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
